// File: rtl/layer_ctrl_pkg.sv
// Shared types for the layer ping-pong scheduler: FSM encodings, bank index,
// debug snapshot struct and the saturating increment used by the stall counter.
package layer_ctrl_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_RUN  = 2'd1,
    P_DONE = 2'd2
  } prod_state_t;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_DONE = 2'd2
  } cons_state_t;

  typedef logic bank_idx_t;

  localparam int STALL_WIDTH = 32;

  // Frame counters are zero-extended to 16 bits for observation.
  typedef struct packed {
    prod_state_t prod_state;
    cons_state_t cons_state;
    bank_idx_t   wr_bank;
    bank_idx_t   rd_bank;
    logic [15:0] produced;
    logic [15:0] consumed;
  } ctrl_debug_t;

  function automatic logic [STALL_WIDTH-1:0] sat_inc(input logic [STALL_WIDTH-1:0] value);
    return (value == {STALL_WIDTH{1'b1}}) ? value : value + STALL_WIDTH'(1);
  endfunction

endpackage

// File: rtl/layer_bank_port_mux.sv
// One feature-buffer bank's port select: producer first, then consumer, else idle zeros.
module layer_bank_port_mux #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  producer_grant,
  input  logic                  consumer_grant,
  input  logic                  p_rden_a,
  input  logic                  p_rden_b,
  input  logic                  p_wren_a,
  input  logic                  p_wren_b,
  input  logic [ADDR_WIDTH-1:0] p_address_a,
  input  logic [ADDR_WIDTH-1:0] p_address_b,
  input  logic                  c_rden_a,
  input  logic                  c_rden_b,
  input  logic                  c_wren_a,
  input  logic                  c_wren_b,
  input  logic [ADDR_WIDTH-1:0] c_address_a,
  input  logic [ADDR_WIDTH-1:0] c_address_b,
  output logic                  rden_a,
  output logic                  rden_b,
  output logic                  wren_a,
  output logic                  wren_b,
  output logic [ADDR_WIDTH-1:0] address_a,
  output logic [ADDR_WIDTH-1:0] address_b
);

  always_comb begin
    rden_a    = 1'b0;
    rden_b    = 1'b0;
    wren_a    = 1'b0;
    wren_b    = 1'b0;
    address_a = '0;
    address_b = '0;
    if (producer_grant) begin
      rden_a    = p_rden_a;
      rden_b    = p_rden_b;
      wren_a    = p_wren_a;
      wren_b    = p_wren_b;
      address_a = p_address_a;
      address_b = p_address_b;
    end else if (consumer_grant) begin
      rden_a    = c_rden_a;
      rden_b    = c_rden_b;
      wren_a    = c_wren_a;
      wren_b    = c_wren_b;
      address_a = c_address_a;
      address_b = c_address_b;
    end
  end

endmodule

// File: rtl/layer_pingpong_scheduler.sv
// Ping-pong scheduler: producer fills one bank while consumer drains the other.
// Optional stall counter enabled by macro LAYER_PINGPONG_PERF_CNT_EN.
module layer_pingpong_scheduler
  import layer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_FRAMES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   producer_enable,
  output logic                   consumer_enable,
  output logic                   producer_reset,
  output logic                   consumer_reset,
  input  logic                   producer_done,
  input  logic                   consumer_done,
  input  logic                   downstream_ready,
  input  logic                   p_rden_a,
  input  logic                   p_rden_b,
  input  logic                   p_wren_a,
  input  logic                   p_wren_b,
  input  logic [ADDR_WIDTH-1:0]  p_address_a,
  input  logic [ADDR_WIDTH-1:0]  p_address_b,
  input  logic                   c_rden_a,
  input  logic                   c_rden_b,
  input  logic                   c_wren_a,
  input  logic                   c_wren_b,
  input  logic [ADDR_WIDTH-1:0]  c_address_a,
  input  logic [ADDR_WIDTH-1:0]  c_address_b,
  output logic                   bank0_rden_a,
  output logic                   bank0_rden_b,
  output logic                   bank0_wren_a,
  output logic                   bank0_wren_b,
  output logic [ADDR_WIDTH-1:0]  bank0_address_a,
  output logic [ADDR_WIDTH-1:0]  bank0_address_b,
  output logic                   bank1_rden_a,
  output logic                   bank1_rden_b,
  output logic                   bank1_wren_a,
  output logic                   bank1_wren_b,
  output logic [ADDR_WIDTH-1:0]  bank1_address_a,
  output logic [ADDR_WIDTH-1:0]  bank1_address_b,
  output logic [1:0]             bank_full,
  output logic                   all_done,
  output logic [STALL_WIDTH-1:0] stall_cycles,
  output ctrl_debug_t            debug
);

  localparam int CNT_W = $clog2(NUM_FRAMES + 1);
  localparam logic [CNT_W-1:0] FRAMES = CNT_W'(NUM_FRAMES);

  prod_state_t      prod_state;
  cons_state_t      cons_state;
  bank_idx_t        wr_bank;
  bank_idx_t        rd_bank;
  logic [CNT_W-1:0] produced;
  logic [CNT_W-1:0] consumed;
  logic             producer_run_q;
  logic             consumer_run_q;
  logic [1:0]       full_next;
  logic             produce_evt;
  logic             consume_evt;

  // Handshake: a layer's done is only honoured while that layer is in RUN; a
  // consumer frame may start only in a cycle where downstream_ready is high.
  assign producer_enable = (prod_state == P_RUN);
  assign consumer_enable = (cons_state == C_RUN);
  assign producer_reset  = producer_enable & ~producer_run_q;
  assign consumer_reset  = consumer_enable & ~consumer_run_q;
  assign produce_evt     = producer_enable & producer_done;
  assign consume_evt     = consumer_enable & consumer_done;

  // Producer and consumer never own the same bank, so set and clear cannot collide.
  always_comb begin
    full_next = bank_full;
    if (produce_evt) full_next[wr_bank] = 1'b1;
    if (consume_evt) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_state     <= P_IDLE;
      cons_state     <= C_IDLE;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      produced       <= '0;
      consumed       <= '0;
      bank_full      <= 2'b00;
      all_done       <= 1'b0;
      producer_run_q <= 1'b0;
      consumer_run_q <= 1'b0;
    end else begin
      producer_run_q <= producer_enable;
      consumer_run_q <= consumer_enable;
      bank_full      <= full_next;
      case (prod_state)
        P_IDLE: begin
          if (produced == FRAMES) prod_state <= P_DONE;
          else if (enable && !bank_full[wr_bank]) prod_state <= P_RUN;
        end
        P_RUN: begin
          if (producer_done) begin
            prod_state <= P_IDLE;
            wr_bank    <= ~wr_bank;
            produced   <= produced + CNT_W'(1);
          end
        end
        default: prod_state <= P_DONE;
      endcase
      case (cons_state)
        C_IDLE: begin
          if (consumed == FRAMES) begin
            cons_state <= C_DONE;
            all_done   <= 1'b1;
          end else if (enable && bank_full[rd_bank] && downstream_ready) begin
            cons_state <= C_RUN;
          end
        end
        C_RUN: begin
          if (consumer_done) begin
            cons_state <= C_IDLE;
            rd_bank    <= ~rd_bank;
            consumed   <= consumed + CNT_W'(1);
          end
        end
        default: cons_state <= C_DONE;
      endcase
    end
  end

`ifdef LAYER_PINGPONG_PERF_CNT_EN
  logic [STALL_WIDTH-1:0] stall_q;
  logic                   stall_now;

  assign stall_now = enable &&
    ((prod_state == P_IDLE && produced != FRAMES && bank_full[wr_bank]) ||
     (cons_state == C_IDLE && consumed != FRAMES &&
      (!bank_full[rd_bank] || !downstream_ready)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_q <= '0;
    else if (stall_now) stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign debug.prod_state = prod_state;
  assign debug.cons_state = cons_state;
  assign debug.wr_bank    = wr_bank;
  assign debug.rd_bank    = rd_bank;
  assign debug.produced   = 16'(produced);
  assign debug.consumed   = 16'(consumed);

  layer_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank0_mux (
    .producer_grant (producer_enable && (wr_bank == 1'b0)),
    .consumer_grant (consumer_enable && (rd_bank == 1'b0)),
    .p_rden_a       (p_rden_a),
    .p_rden_b       (p_rden_b),
    .p_wren_a       (p_wren_a),
    .p_wren_b       (p_wren_b),
    .p_address_a    (p_address_a),
    .p_address_b    (p_address_b),
    .c_rden_a       (c_rden_a),
    .c_rden_b       (c_rden_b),
    .c_wren_a       (c_wren_a),
    .c_wren_b       (c_wren_b),
    .c_address_a    (c_address_a),
    .c_address_b    (c_address_b),
    .rden_a         (bank0_rden_a),
    .rden_b         (bank0_rden_b),
    .wren_a         (bank0_wren_a),
    .wren_b         (bank0_wren_b),
    .address_a      (bank0_address_a),
    .address_b      (bank0_address_b)
  );

  layer_bank_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank1_mux (
    .producer_grant (producer_enable && (wr_bank == 1'b1)),
    .consumer_grant (consumer_enable && (rd_bank == 1'b1)),
    .p_rden_a       (p_rden_a),
    .p_rden_b       (p_rden_b),
    .p_wren_a       (p_wren_a),
    .p_wren_b       (p_wren_b),
    .p_address_a    (p_address_a),
    .p_address_b    (p_address_b),
    .c_rden_a       (c_rden_a),
    .c_rden_b       (c_rden_b),
    .c_wren_a       (c_wren_a),
    .c_wren_b       (c_wren_b),
    .c_address_a    (c_address_a),
    .c_address_b    (c_address_b),
    .rden_a         (bank1_rden_a),
    .rden_b         (bank1_rden_b),
    .wren_a         (bank1_wren_a),
    .wren_b         (bank1_wren_b),
    .address_a      (bank1_address_a),
    .address_b      (bank1_address_b)
  );

endmodule

// File: tb/tb_layer_pingpong_scheduler.sv
// Self-checking bench for layer_pingpong_scheduler: directed scenarios plus
// randomized runs against a frame-level reference model.
module tb_layer_pingpong_scheduler;
  import layer_ctrl_pkg::*;

  localparam int AW = 11;
  localparam int NF = 4;
  localparam int BW = 2 * AW + 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          enable = 1'b0;
  logic          downstream_ready = 1'b0;
  logic          producer_done = 1'b0;
  logic          consumer_done = 1'b0;
  logic          producer_enable, consumer_enable, producer_reset, consumer_reset;
  logic          p_rden_a = 1'b0, p_rden_b = 1'b0, p_wren_a = 1'b0, p_wren_b = 1'b0;
  logic          c_rden_a = 1'b0, c_rden_b = 1'b0, c_wren_a = 1'b0, c_wren_b = 1'b0;
  logic [AW-1:0] p_address_a = '0, p_address_b = '0, c_address_a = '0, c_address_b = '0;
  logic          bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b;
  logic          bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b;
  logic [AW-1:0] bank0_address_a, bank0_address_b, bank1_address_a, bank1_address_b;
  logic [1:0]    bank_full;
  logic          all_done;
  logic [31:0]   stall_cycles;
  ctrl_debug_t   debug;

  layer_pingpong_scheduler #(.ADDR_WIDTH(AW), .NUM_FRAMES(NF)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .producer_enable(producer_enable), .consumer_enable(consumer_enable),
    .producer_reset(producer_reset), .consumer_reset(consumer_reset),
    .producer_done(producer_done), .consumer_done(consumer_done),
    .downstream_ready(downstream_ready),
    .p_rden_a(p_rden_a), .p_rden_b(p_rden_b), .p_wren_a(p_wren_a), .p_wren_b(p_wren_b),
    .p_address_a(p_address_a), .p_address_b(p_address_b),
    .c_rden_a(c_rden_a), .c_rden_b(c_rden_b), .c_wren_a(c_wren_a), .c_wren_b(c_wren_b),
    .c_address_a(c_address_a), .c_address_b(c_address_b),
    .bank0_rden_a(bank0_rden_a), .bank0_rden_b(bank0_rden_b),
    .bank0_wren_a(bank0_wren_a), .bank0_wren_b(bank0_wren_b),
    .bank0_address_a(bank0_address_a), .bank0_address_b(bank0_address_b),
    .bank1_rden_a(bank1_rden_a), .bank1_rden_b(bank1_rden_b),
    .bank1_wren_a(bank1_wren_a), .bank1_wren_b(bank1_wren_b),
    .bank1_address_a(bank1_address_a), .bank1_address_b(bank1_address_b),
    .bank_full(bank_full), .all_done(all_done), .stall_cycles(stall_cycles),
    .debug(debug)
  );

  logic [BW-1:0] bank0_bundle, bank1_bundle;
  assign bank0_bundle = {bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b,
                         bank0_address_a, bank0_address_b};
  assign bank1_bundle = {bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b,
                         bank1_address_a, bank1_address_b};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] p_exp_q[$];
  logic [0:0] c_exp_q[$];
  int p_pulses = 0;
  int c_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit       m_p_run, m_p_fin, m_c_run, m_c_fin, m_p_prev, m_c_prev, m_all_done;
  bit [1:0] m_full;
  int       m_wr, m_rd, m_prod, m_cons;
  longint   m_stall;
  int       p_left, c_left, dmin, dmax;
  bit       force_155 = 1'b0;

  task automatic model_reset();
    m_p_run = 0; m_p_fin = 0; m_c_run = 0; m_c_fin = 0;
    m_p_prev = 0; m_c_prev = 0; m_all_done = 0;
    m_full = 2'b00; m_wr = 0; m_rd = 0; m_prod = 0; m_cons = 0;
    m_stall = 0; p_left = 0; c_left = 0;
  endtask

  task automatic model_step(input bit e, input bit dr, input bit pd, input bit cd);
    bit [1:0] f;
    f = m_full;
    if (e && ((!m_p_run && !m_p_fin && m_prod < NF && m_full[m_wr]) ||
              (!m_c_run && !m_c_fin && m_cons < NF && (!m_full[m_rd] || !dr))))
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
    m_p_prev = m_p_run;
    m_c_prev = m_c_run;
    if (m_p_run) begin
      if (pd) begin
        f[m_wr] = 1'b1; m_wr = 1 - m_wr; m_prod++; m_p_run = 0;
      end else p_left--;
    end else if (!m_p_fin) begin
      if (m_prod == NF) m_p_fin = 1;
      else if (e && !m_full[m_wr]) begin
        m_p_run = 1; p_left = int'($urandom_range(dmax, dmin));
      end
    end
    if (m_c_run) begin
      if (cd) begin
        f[m_rd] = 1'b0; m_rd = 1 - m_rd; m_cons++; m_c_run = 0;
      end else c_left--;
    end else if (!m_c_fin) begin
      if (m_cons == NF) begin
        m_c_fin = 1; m_all_done = 1;
      end else if (e && m_full[m_rd] && dr) begin
        m_c_run = 1; c_left = int'($urandom_range(dmax, dmin));
      end
    end
    m_full = f;
  endtask

  function automatic logic [BW-1:0] exp_bank(input int k);
    logic [BW-1:0] v;
    v = '0;
    if (m_p_run && m_wr == k)
      v = {p_rden_a, p_rden_b, p_wren_a, p_wren_b, p_address_a, p_address_b};
    else if (m_c_run && m_rd == k)
      v = {c_rden_a, c_rden_b, c_wren_a, c_wren_b, c_address_a, c_address_b};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit e, input bit dr, input bit pd, input bit cd);
    @(negedge clock);
    enable = e; downstream_ready = dr; producer_done = pd; consumer_done = cd;
    {p_rden_a, p_rden_b, p_wren_a, p_wren_b} = 4'($urandom_range(0, 15));
    {c_rden_a, c_rden_b, c_wren_a, c_wren_b} = 4'($urandom_range(0, 15));
    p_address_a = AW'($urandom); p_address_b = AW'($urandom);
    c_address_a = AW'($urandom); c_address_b = AW'($urandom);
    if (force_155) p_address_a = 11'h155;
    #1;
    check("producer_enable", producer_enable, m_p_run);
    check("consumer_enable", consumer_enable, m_c_run);
    check("producer_reset", producer_reset, m_p_run && !m_p_prev);
    check("consumer_reset", consumer_reset, m_c_run && !m_c_prev);
    check("bank_full", bank_full, m_full);
    check("all_done", all_done, m_all_done);
`ifdef LAYER_PINGPONG_PERF_CNT_EN
    check("stall_cycles", stall_cycles, 64'(m_stall));
`else
    check("stall_cycles_tied", stall_cycles, 0);
`endif
    check("bank0_ports", bank0_bundle, exp_bank(0));
    check("bank1_ports", bank1_bundle, exp_bank(1));
    if (force_155) begin
      check("addr155_bank1", bank1_address_a, 11'h155);
      check("addr155_bank0", bank0_address_a, (m_c_run && m_rd == 0) ? c_address_a : '0);
    end
    if (producer_reset === 1'b1) begin
      p_pulses++;
      if (p_exp_q.size() > 0) check("p_bank_order", debug.wr_bank, p_exp_q.pop_front());
    end
    if (consumer_reset === 1'b1) begin
      c_pulses++;
      if (c_exp_q.size() > 0) check("c_bank_order", debug.rd_bank, c_exp_q.pop_front());
    end
    @(posedge clock);
    model_step(e, dr, pd, cd);
  endtask

  task automatic run_agent(input int n, input int en_pct, input int dr_pct, input int lo,
                           input int hi, input bit noise, input bit stop_done);
    bit e, dr, pd, cd;
    dmin = lo;
    dmax = hi;
    for (int i = 0; i < n; i++) begin
      e  = int'($urandom_range(0, 99)) < en_pct;
      dr = int'($urandom_range(0, 99)) < dr_pct;
      if (m_p_run) pd = (p_left <= 0);
      else pd = noise && ($urandom_range(0, 1) == 1);
      if (m_c_run) cd = (c_left <= 0);
      else cd = noise && ($urandom_range(0, 1) == 1);
      cycle(e, dr, pd, cd);
      if (stop_done && m_all_done) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    enable = 1'b0; downstream_ready = 1'b0; producer_done = 1'b0; consumer_done = 1'b0;
    force_155 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_producer_enable", producer_enable, 0);
    check("rst_consumer_enable", consumer_enable, 0);
    check("rst_producer_reset", producer_reset, 0);
    check("rst_consumer_reset", consumer_reset, 0);
    check("rst_bank0_ports", bank0_bundle, 0);
    check("rst_bank1_ports", bank1_bundle, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_all_done", all_done, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_produced", debug.produced, 0);
    check("rst_wr_bank", debug.wr_bank, 0);
    check("rst_rd_bank", debug.rd_bank, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Directed run: both layers always permitted, 10-cycle frames.
    do_reset();
    p_exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    c_exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    p_pulses = 0;
    c_pulses = 0;
    run_agent(400, 100, 100, 10, 10, 1'b0, 1'b1);
    run_agent(6, 100, 100, 10, 10, 1'b0, 1'b0);
    #2;
    check("sc1_all_done", all_done, 1);
    check("sc1_p_pulses", p_pulses, 4);
    check("sc1_c_pulses", c_pulses, 4);
    check("sc1_p_order_left", p_exp_q.size(), 0);
    check("sc1_c_order_left", c_exp_q.size(), 0);

    // Downstream never ready: producer fills both banks then waits.
    do_reset();
    run_agent(60, 100, 0, 2, 5, 1'b1, 1'b0);
    #2;
    check("sc2_bank_full", bank_full, 2'b11);
    check("sc2_prod_idle", debug.prod_state, P_IDLE);
    check("sc2_produced", debug.produced, 2);
`ifdef LAYER_PINGPONG_PERF_CNT_EN
    check("sc2_stall_count", stall_cycles, 60);
`else
    check("sc2_stall_zero", stall_cycles, 0);
`endif

    // Producer on bank1 and consumer on bank0 finish in the same cycle.
    do_reset();
    dmin = 20; dmax = 20;
    for (int i = 0; i < 10 && !m_p_run; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("sc3_wait_p0", m_p_run, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && !m_p_run; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("sc3_wait_p1", m_p_run, 1);
    for (int i = 0; i < 10 && !m_c_run; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("sc3_wait_c0", m_c_run, 1);
    force_155 = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    force_155 = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    check("sc3_bank_full", bank_full, 2'b10);
    check("sc3_wr_bank", debug.wr_bank, 0);
    check("sc3_rd_bank", debug.rd_bank, 1);

    // Reset pulsed low in the middle of a producer frame; run restarts at bank0.
    do_reset();
    run_agent(24, 100, 100, 8, 8, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !m_p_run; i++) run_agent(1, 100, 100, 8, 8, 1'b0, 1'b0);
    #2;
    check("sc5_running", producer_enable, 1);
    do_reset();
    p_exp_q = {1'b0};
    c_exp_q = {1'b0};
    run_agent(300, 100, 100, 1, 4, 1'b1, 1'b1);
    #2;
    check("sc5_all_done", all_done, 1);

    // Randomized runs with dropped enable, flaky downstream_ready and stray done strobes.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      run_agent(400, 85, 70, 0, 6, 1'b1, 1'b1);
      #2;
      check("rand_all_done", all_done, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
